// File: rtl/rx_ctrl_pkg.sv
// Shared UART receive types: frame/data widths and the FIFO entry layout.
// Provides package uart_pkg, imported by rx_fifo and rx_ctrl.
package uart_pkg;

  localparam int unsigned UART_MAX_DATA_W = 9;
  localparam int unsigned UART_FRAME_W    = 11;

  typedef struct packed {
    logic                       fe;
    logic                       pe;
    logic [UART_MAX_DATA_W-1:0] data;
  } rx_entry_t;

  // 8-bit mode zero-extends so the host always sees a 9-bit field.
  function automatic logic [UART_MAX_DATA_W-1:0] rx_extract_data(
    input logic [UART_FRAME_W-1:0] frame,
    input logic                    ds
  );
    return ds ? frame[8:0] : {1'b0, frame[7:0]};
  endfunction

endpackage

// File: rtl/rx_ctrl_if.sv
// Bundle of line configuration, frontend frame handoff and host FIFO access for rx_ctrl.
// master = frontend/host side, slave = rx_ctrl.
interface rx_ctrl_if #(
  parameter int unsigned DEPTH = 8
) ();
  import uart_pkg::*;

  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic                       cr_en_i;
  logic                       cr_ds_i;
  logic [1:0]                 cr_p_i;
  logic [UART_FRAME_W-1:0]    frame_i;
  logic                       parity_err_i;
  logic                       frame_err_i;
  logic                       frame_valid_i;
  logic                       rd_i;
  logic                       flush_i;
  logic                       clr_i;
  logic [UART_MAX_DATA_W-1:0] data_o;
  logic                       pe_o;
  logic                       fe_o;
  logic                       empty_o;
  logic                       full_o;
  logic [LW-1:0]              level_o;
  logic                       overrun_o;
  logic                       timeout_o;
  logic                       irq_o;

  modport master (
    output cr_en_i, cr_ds_i, cr_p_i, frame_i, parity_err_i, frame_err_i,
           frame_valid_i, rd_i, flush_i, clr_i,
    input  data_o, pe_o, fe_o, empty_o, full_o, level_o, overrun_o,
           timeout_o, irq_o
  );

  modport slave (
    input  cr_en_i, cr_ds_i, cr_p_i, frame_i, parity_err_i, frame_err_i,
           frame_valid_i, rd_i, flush_i, clr_i,
    output data_o, pe_o, fe_o, empty_o, full_o, level_o, overrun_o,
           timeout_o, irq_o
  );

endinterface

// File: rtl/rx_ctrl_fifo.sv
// rx_fifo: single-clock show-ahead FIFO of rx_entry_t with flush and level.
// Full/empty use an extra pointer MSB; flush overrides write and read.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  rx_entry_t     wdata_i,
  input  logic          rd_i,
  input  logic          flush_i,
  output rx_entry_t     rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [LW-1:0] level_o,
  output logic [LW-1:0] level_next_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  rx_entry_t     mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          rd_en, wr_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on a full FIFO frees the slot that the same-cycle write uses.
  assign rd_en = rd_i & ~empty_o;
  assign wr_en = wr_i & (~full_o | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o      = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level_o      = LW'(wr_ptr_q - rd_ptr_q);
  assign level_next_o = LW'(wr_ptr_d - rd_ptr_d);

endmodule

// File: rtl/rx_ctrl.sv
// rx_ctrl: frame edge capture, data extraction, sticky status and irq over rx_fifo.
// Optional idle timeout enabled by defining RX_TIMEOUT_EN.
module rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned IRQ_THRESHOLD  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic    clk_i,
  input  logic    rst_i,
  rx_ctrl_if.slave bus
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("rx_ctrl: DEPTH must be a power of two >= 2");
  end
  if ((IRQ_THRESHOLD < 1) || (IRQ_THRESHOLD > DEPTH)) begin : g_chk_thr
    $error("rx_ctrl: IRQ_THRESHOLD out of range");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_to
    $error("rx_ctrl: TIMEOUT_CYCLES must be >= 1");
  end

  logic          fv_q;
  logic          accept;
  rx_entry_t     entry;
  rx_entry_t     head;
  logic          empty, full;
  logic [LW-1:0] level, level_next;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          irq_q, irq_d;

  assign accept = bus.cr_en_i & bus.frame_valid_i & ~fv_q;

  always_comb begin
    entry      = '0;
    entry.data = rx_extract_data(bus.frame_i, bus.cr_ds_i);
    entry.pe   = bus.parity_err_i & (bus.cr_p_i != 2'b00);
    entry.fe   = bus.frame_err_i;
  end

  rx_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_i         (accept),
    .wdata_i      (entry),
    .rd_i         (bus.rd_i),
    .flush_i      (bus.flush_i),
    .rdata_o      (head),
    .empty_o      (empty),
    .full_o       (full),
    .level_o      (level),
    .level_next_o (level_next)
  );

  // When full the FIFO is non-empty, so any rd_i makes room for the frame.
  assign overrun_d = (accept & full & ~bus.rd_i & ~bus.flush_i) |
                     (overrun_q & ~bus.clr_i);

`ifdef RX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] idle_q, idle_d;
  logic          timeout_set;

  always_comb begin
    idle_d      = idle_q;
    timeout_set = 1'b0;
    if (accept || bus.rd_i) begin
      idle_d = '0;
    end else if (!empty && (idle_q != CW'(TIMEOUT_CYCLES))) begin
      idle_d      = idle_q + 1'b1;
      timeout_set = (idle_d == CW'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign timeout_d = timeout_set | (timeout_q & ~bus.clr_i);
`else
  assign timeout_d = 1'b0;
`endif

  assign irq_d = (level_next >= LW'(IRQ_THRESHOLD)) | overrun_d | timeout_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fv_q      <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      fv_q      <= bus.frame_valid_i;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.data_o    = head.data;
  assign bus.pe_o      = head.pe;
  assign bus.fe_o      = head.fe;
  assign bus.empty_o   = empty;
  assign bus.full_o    = full;
  assign bus.level_o   = level;
  assign bus.overrun_o = overrun_q;
  assign bus.timeout_o = timeout_q;
  assign bus.irq_o     = irq_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed self-checking bench for rx_ctrl (DEPTH=8, IRQ_THRESHOLD=1).
// With RX_TIMEOUT_EN defined the timeout is exercised at TIMEOUT_CYCLES=16.
module tb_rx_ctrl;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 4096;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rx_ctrl_if #(.DEPTH(8)) bus ();

  rx_ctrl #(
    .DEPTH          (8),
    .IRQ_THRESHOLD  (1),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [10:0] f);
    bus.frame_i       = f;
    bus.frame_valid_i = 1'b1;
    step();
    bus.frame_valid_i = 1'b0;
    step();
  endtask

  task automatic pop();
    bus.rd_i = 1'b1;
    step();
    bus.rd_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.cr_en_i = 1'b0; bus.cr_ds_i = 1'b0; bus.cr_p_i = 2'b00;
    bus.frame_i = '0; bus.parity_err_i = 1'b0; bus.frame_err_i = 1'b0;
    bus.frame_valid_i = 1'b0; bus.rd_i = 1'b0; bus.flush_i = 1'b0; bus.clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", bus.empty_o, 1);
    check("rst_full", bus.full_o, 0);
    check("rst_level", bus.level_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_pe_fe", {bus.pe_o, bus.fe_o}, 0);
    check("rst_flags", {bus.overrun_o, bus.timeout_o, bus.irq_o}, 0);
    rst = 1'b0;
    step();

    // 8-bit frame, visible on the cycle after the edge
    bus.cr_en_i = 1'b1;
    bus.frame_i = 11'h6A5;
    bus.frame_valid_i = 1'b1;
    step();
    check("d8_data", bus.data_o, 9'h0A5);
    check("d8_empty", bus.empty_o, 0);
    check("d8_level", bus.level_o, 1);
    check("d8_irq", bus.irq_o, 1);
    bus.frame_valid_i = 1'b0;
    step();
    pop();
    check("pop_empty", bus.empty_o, 1);
    check("pop_irq", bus.irq_o, 0);

    // 9-bit data, parity gating, frame error
    bus.cr_ds_i = 1'b1;
    bus.parity_err_i = 1'b1;
    send(11'h5A5);
    check("d9_data", bus.data_o, 9'h1A5);
    check("pe_disabled", bus.pe_o, 0);
    pop();
    bus.cr_p_i = 2'b01;
    send(11'h5A5);
    check("pe_enabled", bus.pe_o, 1);
    pop();
    bus.parity_err_i = 1'b0;
    bus.frame_err_i = 1'b1;
    send(11'h0F0);
    check("fe_set", {bus.fe_o, bus.pe_o}, 2'b10);
    pop();
    bus.frame_err_i = 1'b0;

    // Fill past capacity
    for (int i = 0; i < 9; i++) send(11'(16 + i));
    check("fill_full", bus.full_o, 1);
    check("fill_level", bus.level_o, 8);
    check("fill_overrun", bus.overrun_o, 1);
    check("fill_irq", bus.irq_o, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), bus.data_o, 9'(16 + i));
      pop();
    end
    check("drain_empty", bus.empty_o, 1);
    check("overrun_sticky", bus.overrun_o, 1);
    bus.clr_i = 1'b1;
    step();
    bus.clr_i = 1'b0;
    check("overrun_clr", bus.overrun_o, 0);
    check("clr_irq", bus.irq_o, 0);

    // Full + accept + pop in the same cycle
    for (int i = 0; i < 8; i++) send(11'(32 + i));
    bus.frame_i = 11'h055;
    bus.frame_valid_i = 1'b1;
    bus.rd_i = 1'b1;
    step();
    bus.frame_valid_i = 1'b0;
    bus.rd_i = 1'b0;
    check("fullrw_level", bus.level_o, 8);
    check("fullrw_overrun", bus.overrun_o, 0);
    check("fullrw_head", bus.data_o, 9'h021);
    step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("flush_level", bus.level_o, 0);
    check("flush_empty", bus.empty_o, 1);

    // Pop while empty
    pop();
    check("rdempty_level", bus.level_o, 0);
    check("rdempty_empty", {bus.empty_o, bus.full_o}, 2'b10);

    // Level held high counts once
    bus.frame_i = 11'h033;
    bus.frame_valid_i = 1'b1;
    repeat (5) step();
    bus.frame_valid_i = 1'b0;
    step();
    check("held_level", bus.level_o, 1);
    check("held_data", bus.data_o, 9'h033);

    // Flush with simultaneous edge discards the frame
    bus.frame_i = 11'h034;
    bus.frame_valid_i = 1'b1;
    bus.flush_i = 1'b1;
    step();
    bus.frame_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check("flushedge_level", bus.level_o, 0);
    check("flushedge_ovr", bus.overrun_o, 0);
    check("flushedge_irq", bus.irq_o, 0);
    step();

    // Disabled receiver ignores frames
    bus.cr_en_i = 1'b0;
    send(11'h044);
    check("dis_level", bus.level_o, 0);
    bus.cr_en_i = 1'b1;

    // Empty + accept + pop: pop ignored
    bus.frame_i = 11'h066;
    bus.frame_valid_i = 1'b1;
    bus.rd_i = 1'b1;
    step();
    bus.frame_valid_i = 1'b0;
    bus.rd_i = 1'b0;
    check("emptyrw_level", bus.level_o, 1);
    check("emptyrw_data", bus.data_o, 9'h066);
    step();

    // Enable dropped on the edge; re-enabling with valid still high is not an edge
    bus.cr_en_i = 1'b0;
    bus.frame_i = 11'h070;
    bus.frame_valid_i = 1'b1;
    step();
    bus.cr_en_i = 1'b1;
    step();
    bus.frame_valid_i = 1'b0;
    step();
    check("enfall_level", bus.level_o, 1);
    check("enfall_data", bus.data_o, 9'h066);

    // Idle timeout
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    bus.frame_i = 11'h077;
    bus.frame_valid_i = 1'b1;
    step();
    bus.frame_valid_i = 1'b0;
`ifdef RX_TIMEOUT_EN
    repeat (15) step();
    check("to_before", bus.timeout_o, 0);
    step();
    check("to_set", bus.timeout_o, 1);
    check("to_irq", bus.irq_o, 1);
    bus.clr_i = 1'b1;
    step();
    bus.clr_i = 1'b0;
    check("to_clr", bus.timeout_o, 0);
`else
    repeat (20) step();
    check("to_off", bus.timeout_o, 0);
`endif

    // Asynchronous reset between edges
    check("prereset_level", bus.level_o, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_empty", bus.empty_o, 1);
    check("arst_level", bus.level_o, 0);
    check("arst_flags", {bus.overrun_o, bus.timeout_o, bus.irq_o}, 0);
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
